// File: rtl/ma_channel_sequencer.sv
// ma_channel_sequencer
// Time-shares one 2-channel interleaved moving-average FIR between two ECG
// sample streams. Samples enter the filter in strict ch0/ch1 alternation. A tag
// FIFO records, for each sample in flight, which channel it came from and
// whether it was a zero pad. Each filter result pops one tag and is rescaled,
// then either sent to its channel or dropped.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   s0_axis_*          ch0 sample input (valid/ready)
//   s1_axis_*          ch1 sample input (valid/ready)
//   f_axis_*           sample stream to the filter (valid/ready)
//   f_res_*            filter result stream (valid only, no back-pressure)
//   m0_axis_*          ch0 result, one-cycle tvalid pulse, tdata held
//   m1_axis_*          ch1 result, one-cycle tvalid pulse, tdata held
//   in_flight          tag FIFO occupancy
//   pad_count          zero pads inserted, saturating
//   err_orphan         sticky: a result arrived while no sample was in flight
//
// Handshake: a beat moves on a valid/ready interface in the cycle where both
// tvalid and tready are high. tvalid never depends on tready. The input side
// only offers the channel whose turn it is. The other channel sees tready=0.
module ma_channel_sequencer #(
  parameter int DW          = 32,
  parameter int FW          = 52,
  parameter int SHIFT       = 20,
  parameter int DEPTH       = 16,
  parameter int PAD_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s0_axis_tvalid,
  input  logic [DW-1:0]            s0_axis_tdata,
  output logic                     s0_axis_tready,
  input  logic                     s1_axis_tvalid,
  input  logic [DW-1:0]            s1_axis_tdata,
  output logic                     s1_axis_tready,
  output logic                     f_axis_tvalid,
  output logic [DW-1:0]            f_axis_tdata,
  input  logic                     f_axis_tready,
  input  logic                     f_res_tvalid,
  input  logic [FW-1:0]            f_res_tdata,
  output logic                     m0_axis_tvalid,
  output logic [DW-1:0]            m0_axis_tdata,
  output logic                     m1_axis_tvalid,
  output logic [DW-1:0]            m1_axis_tdata,
  output logic [$clog2(DEPTH):0]   in_flight,
  output logic [15:0]              pad_count,
  output logic                     err_orphan
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Tag layout: bit 1 = pad, bit 0 = channel.
  logic [1:0]    tag_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    head_tag;

  logic          next_ch;
  logic          credit;
  logic          pad_req;
  logic          sel_valid;
  logic          other_valid;
  logic [DW-1:0] sel_data;
  logic          push;
  logic          pop;
  logic [DW-1:0] res_scaled;

  assign sel_valid   = next_ch ? s1_axis_tvalid : s0_axis_tvalid;
  assign other_valid = next_ch ? s0_axis_tvalid : s1_axis_tvalid;
  assign sel_data    = next_ch ? s1_axis_tdata  : s0_axis_tdata;
  assign credit      = (count < DEPTH_C);

  // A pending pad takes the slot of the expected channel, so that channel is
  // held off until the zero sample has gone in.
  always_comb begin
    f_axis_tvalid  = (sel_valid | pad_req) & credit;
    f_axis_tdata   = pad_req ? '0 : sel_data;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (next_ch) s1_axis_tready = f_axis_tready & credit & ~pad_req;
    else         s0_axis_tready = f_axis_tready & credit & ~pad_req;
  end

  assign push     = f_axis_tvalid & f_axis_tready;
  assign pop      = f_res_tvalid & (count != '0);
  assign head_tag = tag_mem[rd_ptr];

  // Tag storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= {pad_req, next_ch};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      next_ch <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        next_ch <= ~next_ch;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign in_flight = count;

  generate
    if (PAD_TIMEOUT > 0) begin : g_pad
      localparam int TW = $clog2(PAD_TIMEOUT + 1);
      localparam logic [TW-1:0] LIMIT = TW'(PAD_TIMEOUT);
      logic [TW-1:0] timer;

      assign pad_req = (timer == LIMIT);

      // Once the limit is reached the timer parks there, keeping the pad
      // request up until the pad actually enters the filter.
      always_ff @(posedge clk) begin
        if (rst) begin
          timer <= '0;
        end else if (push && pad_req) begin
          timer <= '0;
        end else if (pad_req) begin
          timer <= timer;
        end else if (!sel_valid && other_valid) begin
          timer <= timer + 1'b1;
        end else begin
          timer <= '0;
        end
      end
    end else begin : g_no_pad
      assign pad_req = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_count <= '0;
    end else if (push && pad_req && (pad_count != 16'hFFFF)) begin
      pad_count <= pad_count + 16'd1;
    end
  end

  // Arithmetic shift keeps the sign; the cast drops the upper bits.
  assign res_scaled = DW'($signed(f_res_tdata) >>> SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_axis_tvalid <= 1'b0;
      m0_axis_tdata  <= '0;
      m1_axis_tvalid <= 1'b0;
      m1_axis_tdata  <= '0;
      err_orphan     <= 1'b0;
    end else begin
      m0_axis_tvalid <= 1'b0;
      m1_axis_tvalid <= 1'b0;
      if (f_res_tvalid) begin
        if (count == '0) begin
          err_orphan <= 1'b1;
        end else if (!head_tag[1]) begin
          if (head_tag[0]) begin
            m1_axis_tvalid <= 1'b1;
            m1_axis_tdata  <= res_scaled;
          end else begin
            m0_axis_tvalid <= 1'b1;
            m0_axis_tdata  <= res_scaled;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ma_channel_sequencer.sv
// Testbench for ma_channel_sequencer. A single-threaded step() task advances
// one clock, runs a behavioural filter model, and keeps a reference model
// built from the sequencing rules (turn-taking, in-flight tags, pad policy,
// result routing) to predict every observable output.
module tb_ma_channel_sequencer;
  localparam int DW    = 32;
  localparam int FW    = 52;
  localparam int SHIFT = 20;
  localparam int DEPTH = 16;
  localparam int PT    = 4;
  localparam int LAT   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          s0_axis_tvalid, s0_axis_tready;
  logic [DW-1:0] s0_axis_tdata;
  logic          s1_axis_tvalid, s1_axis_tready;
  logic [DW-1:0] s1_axis_tdata;
  logic          f_axis_tvalid, f_axis_tready;
  logic [DW-1:0] f_axis_tdata;
  logic          f_res_tvalid;
  logic [FW-1:0] f_res_tdata;
  logic          m0_axis_tvalid, m1_axis_tvalid;
  logic [DW-1:0] m0_axis_tdata, m1_axis_tdata;
  logic [4:0]    in_flight;
  logic [15:0]   pad_count;
  logic          err_orphan;

  ma_channel_sequencer #(
    .DW(DW), .FW(FW), .SHIFT(SHIFT), .DEPTH(DEPTH), .PAD_TIMEOUT(PT)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tdata(s0_axis_tdata), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tdata(s1_axis_tdata), .s1_axis_tready(s1_axis_tready),
    .f_axis_tvalid(f_axis_tvalid), .f_axis_tdata(f_axis_tdata), .f_axis_tready(f_axis_tready),
    .f_res_tvalid(f_res_tvalid), .f_res_tdata(f_res_tdata),
    .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tdata(m0_axis_tdata),
    .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tdata(m1_axis_tdata),
    .in_flight(in_flight), .pad_count(pad_count), .err_orphan(err_orphan)
  );

  typedef struct packed {
    int unsigned   due;
    logic [FW-1:0] data;
  } res_t;

  // Filter model and reference model state.
  res_t          fq[$];
  logic [1:0]    tag_q[$];
  logic [DW-1:0] exp0_q[$];
  int unsigned   exp0_due[$];
  logic [DW-1:0] exp1_q[$];
  int unsigned   exp1_due[$];
  int unsigned   cyc;
  logic          exp_ch;
  logic [15:0]   exp_pads;
  logic          exp_orphan;
  logic [DW-1:0] last0, last1;
  int            stall;
  logic          pad_pend;
  bit            filter_en;

  // Per-window observations for the scenario tasks.
  logic acc0, acc1, last_xfer, last_fvalid;
  int   pulses0, pulses1;

  int n_cmp, n_bad;

  // Floor division by 2^SHIFT, then keep the low DW bits.
  function automatic logic [DW-1:0] rescale(input logic [FW-1:0] r);
    longint v, d, q;
    v = longint'($signed(r));
    d = longint'(1) <<< SHIFT;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
    return q[DW-1:0];
  endfunction

  task automatic step();
    logic          m0_due, m1_due, sel_v, oth_v, want_pad, full, xfer;
    logic          want_fv, want_r0, want_r1;
    logic [DW-1:0] want_data;
    logic [1:0]    tag;
    logic [FW-1:0] fr;
    @(negedge clk);
    // Result outputs
    m0_due = (exp0_q.size() > 0) && (exp0_due[0] <= cyc);
    m1_due = (exp1_q.size() > 0) && (exp1_due[0] <= cyc);
    n_cmp++;
    if (m0_axis_tvalid !== m0_due) begin
      n_bad++; $display("FAIL m0_tvalid cyc=%0d got=%b want=%b", cyc, m0_axis_tvalid, m0_due);
    end
    n_cmp++;
    if (m1_axis_tvalid !== m1_due) begin
      n_bad++; $display("FAIL m1_tvalid cyc=%0d got=%b want=%b", cyc, m1_axis_tvalid, m1_due);
    end
    if (m0_due) begin last0 = exp0_q.pop_front(); void'(exp0_due.pop_front()); end
    if (m1_due) begin last1 = exp1_q.pop_front(); void'(exp1_due.pop_front()); end
    n_cmp++;
    if (m0_axis_tdata !== last0) begin
      n_bad++; $display("FAIL m0_tdata cyc=%0d got=%0d want=%0d", cyc, $signed(m0_axis_tdata), $signed(last0));
    end
    n_cmp++;
    if (m1_axis_tdata !== last1) begin
      n_bad++; $display("FAIL m1_tdata cyc=%0d got=%0d want=%0d", cyc, $signed(m1_axis_tdata), $signed(last1));
    end
    if (m0_axis_tvalid === 1'b1) pulses0++;
    if (m1_axis_tvalid === 1'b1) pulses1++;
    // Status outputs
    n_cmp++;
    if (in_flight !== 5'(tag_q.size())) begin
      n_bad++; $display("FAIL in_flight cyc=%0d got=%0d want=%0d", cyc, in_flight, tag_q.size());
    end
    n_cmp++;
    if (pad_count !== exp_pads) begin
      n_bad++; $display("FAIL pad_count cyc=%0d got=%0d want=%0d", cyc, pad_count, exp_pads);
    end
    n_cmp++;
    if (err_orphan !== exp_orphan) begin
      n_bad++; $display("FAIL err_orphan cyc=%0d got=%b want=%b", cyc, err_orphan, exp_orphan);
    end
    // Input side: whose turn, credit, pad
    sel_v    = exp_ch ? s1_axis_tvalid : s0_axis_tvalid;
    oth_v    = exp_ch ? s0_axis_tvalid : s1_axis_tvalid;
    full     = (tag_q.size() >= DEPTH);
    want_pad = pad_pend;
    want_fv  = (sel_v | want_pad) & ~full;
    want_r0  = ~exp_ch & f_axis_tready & ~full & ~want_pad;
    want_r1  =  exp_ch & f_axis_tready & ~full & ~want_pad;
    n_cmp++;
    if (f_axis_tvalid !== want_fv) begin
      n_bad++; $display("FAIL f_tvalid cyc=%0d got=%b want=%b", cyc, f_axis_tvalid, want_fv);
    end
    n_cmp++;
    if ({s1_axis_tready, s0_axis_tready} !== {want_r1, want_r0}) begin
      n_bad++; $display("FAIL s_tready cyc=%0d got=%b%b want=%b%b", cyc,
                        s1_axis_tready, s0_axis_tready, want_r1, want_r0);
    end
    xfer        = want_fv & f_axis_tready;
    last_xfer   = xfer;
    last_fvalid = f_axis_tvalid;
    acc0        = s0_axis_tvalid & s0_axis_tready;
    acc1        = s1_axis_tvalid & s1_axis_tready;
    if (xfer) begin
      want_data = want_pad ? '0 : (exp_ch ? s1_axis_tdata : s0_axis_tdata);
      n_cmp++;
      if (f_axis_tdata !== want_data) begin
        n_bad++; $display("FAIL f_tdata cyc=%0d got=%0d want=%0d", cyc, $signed(f_axis_tdata), $signed(want_data));
      end
    end
    // Model update for the coming clock edge
    if (rst) begin
      tag_q.delete(); exp0_q.delete(); exp0_due.delete(); exp1_q.delete(); exp1_due.delete();
      exp_ch = 1'b0; exp_pads = '0; exp_orphan = 1'b0; last0 = '0; last1 = '0;
      stall = 0; pad_pend = 1'b0;
    end else begin
      if (f_res_tvalid) begin
        if (tag_q.size() == 0) begin
          exp_orphan = 1'b1;
        end else begin
          tag = tag_q.pop_front();
          if (!tag[1]) begin
            if (tag[0]) begin exp1_q.push_back(rescale(f_res_tdata)); exp1_due.push_back(cyc + 1); end
            else        begin exp0_q.push_back(rescale(f_res_tdata)); exp0_due.push_back(cyc + 1); end
          end
        end
      end
      if (xfer && want_pad) begin
        stall = 0; pad_pend = 1'b0;
      end else if (!pad_pend) begin
        if (!sel_v && oth_v) stall++;
        else stall = 0;
        if (stall >= PT) pad_pend = 1'b1;
      end
      if (xfer) begin
        tag_q.push_back({want_pad, exp_ch});
        if (want_pad && exp_pads != 16'hFFFF) exp_pads++;
        exp_ch = ~exp_ch;
        if (filter_en) begin
          fr = (FW'($signed(f_axis_tdata)) << SHIFT) | FW'($urandom_range(0, (1 << SHIFT) - 1));
          fq.push_back('{due: cyc + LAT, data: fr});
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (filter_en) begin
      if (fq.size() > 0 && fq[0].due == cyc) begin
        f_res_tvalid = 1'b1;
        f_res_tdata  = fq[0].data;
        void'(fq.pop_front());
      end else begin
        f_res_tvalid = 1'b0;
        f_res_tdata  = '0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    s0_axis_tdata = '0; s1_axis_tdata = '0;
    f_axis_tready = 1'b0; f_res_tvalid = 1'b0; f_res_tdata = '0;
    filter_en = 1'b0;
    fq.delete();
    step(); step();
    rst = 1'b0;
    pulses0 = 0; pulses1 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({m0_axis_tvalid, m1_axis_tvalid, f_axis_tvalid, s0_axis_tready, s1_axis_tready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_valids got=%b want=00000",
                        {m0_axis_tvalid, m1_axis_tvalid, f_axis_tvalid, s0_axis_tready, s1_axis_tready});
    end
    n_cmp++;
    if ({m0_axis_tdata, m1_axis_tdata} !== 64'd0) begin
      n_bad++; $display("FAIL reset_mdata got=%h %h want=0", m0_axis_tdata, m1_axis_tdata);
    end
    n_cmp++;
    if ({in_flight, pad_count, err_orphan} !== 22'd0) begin
      n_bad++; $display("FAIL reset_status got in_flight=%0d pads=%0d orphan=%b want 0",
                        in_flight, pad_count, err_orphan);
    end
  endtask

  task automatic test_alternation();
    do_reset();
    filter_en = 1'b1;
    s0_axis_tdata = 32'd100; s1_axis_tdata = -32'sd7;
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1; f_axis_tready = 1'b1;
    repeat (40) step();
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    repeat (12) step();
    n_cmp++;
    if (pulses0 !== 20 || pulses1 !== 20) begin
      n_bad++; $display("FAIL alt_pulses got=%0d/%0d want=20/20", pulses0, pulses1);
    end
    n_cmp++;
    if (m0_axis_tdata !== 32'd100 || m1_axis_tdata !== 32'hFFFFFFF9) begin
      n_bad++; $display("FAIL alt_data got=%0d/%0d want=100/-7", $signed(m0_axis_tdata), $signed(m1_axis_tdata));
    end
  endtask

  task automatic test_pad();
    int first_fv, acc_win;
    do_reset();
    filter_en = 1'b1;
    s1_axis_tdata = 32'd55; s1_axis_tvalid = 1'b1; f_axis_tready = 1'b1;
    first_fv = -1; acc_win = -1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (last_fvalid && first_fv < 0) first_fv = i;
      if (acc1 && acc_win < 0) begin acc_win = i; s1_axis_tvalid = 1'b0; end
    end
    n_cmp++;
    if (first_fv !== PT) begin
      n_bad++; $display("FAIL pad_window got=%0d want=%0d", first_fv, PT);
    end
    n_cmp++;
    if (acc_win !== PT + 1) begin
      n_bad++; $display("FAIL pad_then_ch1 got=%0d want=%0d", acc_win, PT + 1);
    end
    n_cmp++;
    if (pad_count !== 16'd1 || pulses0 !== 0 || pulses1 !== 1) begin
      n_bad++; $display("FAIL pad_result got pads=%0d m0=%0d m1=%0d want 1/0/1", pad_count, pulses0, pulses1);
    end
  endtask

  task automatic test_full();
    int n;
    do_reset();
    s0_axis_tdata = $urandom; s1_axis_tdata = $urandom;
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1; f_axis_tready = 1'b1;
    n = 0;
    repeat (24) begin step(); if (last_xfer) n++; end
    n_cmp++;
    if (n !== DEPTH) begin
      n_bad++; $display("FAIL full_count got=%0d want=%0d", n, DEPTH);
    end
    n_cmp++;
    if ({f_axis_tvalid, s0_axis_tready, s1_axis_tready} !== 3'b000) begin
      n_bad++; $display("FAIL full_block got=%b want=000", {f_axis_tvalid, s0_axis_tready, s1_axis_tready});
    end
    f_res_tvalid = 1'b1; f_res_tdata = FW'($urandom);
    step();
    f_res_tvalid = 1'b0; f_res_tdata = '0;
    n = 0;
    repeat (10) begin step(); if (last_xfer) n++; end
    n_cmp++;
    if (n !== 1) begin
      n_bad++; $display("FAIL full_resume got=%0d want=1", n);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    f_res_tvalid = 1'b1; f_res_tdata = FW'(12345);
    step();
    f_res_tvalid = 1'b0; f_res_tdata = '0;
    repeat (4) step();
    n_cmp++;
    if (err_orphan !== 1'b1 || pulses0 !== 0 || pulses1 !== 0) begin
      n_bad++; $display("FAIL orphan got err=%b m0=%0d m1=%0d want 1/0/0", err_orphan, pulses0, pulses1);
    end
    do_reset();
    n_cmp++;
    if (err_orphan !== 1'b0) begin
      n_bad++; $display("FAIL orphan_clear got=%b want=0", err_orphan);
    end
  endtask

  task automatic test_push_pop_rst();
    do_reset();
    s0_axis_tdata = $urandom; s1_axis_tdata = $urandom;
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1; f_axis_tready = 1'b1;
    for (int i = 0; i < 20 && tag_q.size() < 5; i++) step();
    f_res_tvalid = 1'b1; f_res_tdata = FW'($urandom);
    step();
    f_res_tvalid = 1'b0; f_res_tdata = '0;
    n_cmp++;
    if (in_flight !== 5'd5) begin
      n_bad++; $display("FAIL push_pop got=%0d want=5", in_flight);
    end
    step();
    f_axis_tready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    f_axis_tready = 1'b1;
    #1;
    n_cmp++;
    if (in_flight !== 5'd0 || m0_axis_tvalid !== 1'b0 || m1_axis_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid got in_flight=%0d m0v=%b m1v=%b want 0/0/0",
                        in_flight, m0_axis_tvalid, m1_axis_tvalid);
    end
    n_cmp++;
    if ({s0_axis_tready, s1_axis_tready} !== 2'b10) begin
      n_bad++; $display("FAIL rst_next_ch got=%b%b want=10", s0_axis_tready, s1_axis_tready);
    end
    step();
  endtask

  task automatic test_shift();
    do_reset();
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1; f_axis_tready = 1'b1;
    step(); step();
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    f_res_tvalid = 1'b1; f_res_tdata = '0 - (FW'(3) << SHIFT) - FW'(1);
    step();
    f_res_tdata = {1'b0, {(FW-1){1'b1}}};
    step();
    f_res_tvalid = 1'b0; f_res_tdata = '0;
    n_cmp++;
    if (m0_axis_tdata !== 32'hFFFFFFFC) begin
      n_bad++; $display("FAIL shift_neg got=%h want=fffffffc", m0_axis_tdata);
    end
    n_cmp++;
    if (m1_axis_tvalid !== 1'b1 || m1_axis_tdata !== 32'h7FFFFFFF) begin
      n_bad++; $display("FAIL shift_max got v=%b d=%h want 1/7fffffff", m1_axis_tvalid, m1_axis_tdata);
    end
    step();
  endtask

  task automatic test_random();
    int p0, p1;
    do_reset();
    filter_en = 1'b1;
    p0 = 3; p1 = 3;
    for (int i = 0; i < 400; i++) begin
      if (i % 32 == 0) begin p0 = $urandom_range(0, 4); p1 = $urandom_range(0, 4); end
      f_axis_tready = ($urandom_range(0, 3) != 0);
      if (!s0_axis_tvalid || acc0) begin
        s0_axis_tvalid = ($urandom_range(0, 3) < p0);
        s0_axis_tdata  = $urandom;
      end
      if (!s1_axis_tvalid || acc1) begin
        s1_axis_tvalid = ($urandom_range(0, 3) < p1);
        s1_axis_tdata  = $urandom;
      end
      step();
    end
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0; f_axis_tready = 1'b1;
    repeat (24) step();
    n_cmp++;
    if (exp0_q.size() + exp1_q.size() + tag_q.size() !== 0) begin
      n_bad++; $display("FAIL random_drain got pending=%0d want=0", exp0_q.size() + exp1_q.size() + tag_q.size());
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    exp_ch = 1'b0; exp_pads = '0; exp_orphan = 1'b0; last0 = '0; last1 = '0;
    stall = 0; pad_pend = 1'b0; filter_en = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0; last_xfer = 1'b0; last_fvalid = 1'b0;
    pulses0 = 0; pulses1 = 0;
    rst = 1'b1;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0; s0_axis_tdata = '0; s1_axis_tdata = '0;
    f_axis_tready = 1'b0; f_res_tvalid = 1'b0; f_res_tdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alternation();
    test_pad();
    test_full();
    test_orphan();
    test_push_pop_rst();
    test_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ma_channel_sequencer.md
Name: ma_channel_sequencer

Overview:
- Shares one 2-channel interleaved moving-average FIR instance between two ECG sample streams (ch0, ch1) in the QRS detection path.
- Enforces the strict ch0/ch1 alternation the interleaved filter requires, tracks in-flight samples with a tag FIFO, and routes each filter output back to its channel.
- Pads a stalled channel with zero samples after a timeout so the other channel is not starved.
- Rescales the wide filter output back to sample width.

Parameters:
- DW, 32: input/output sample width (signed).
- FW, 52: filter output width (signed).
- SHIFT, 20: arithmetic right shift applied to the filter output.
- DEPTH, 16: maximum samples in flight inside the filter; tag FIFO depth; power of 2.
- PAD_TIMEOUT, 1024: cycles the expected channel may stall while the other waits before a pad is inserted; 0 disables padding.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s0_axis_tvalid  in  1  ch0 sample valid
- s0_axis_tdata  in  DW  ch0 sample, signed
- s0_axis_tready  out  1  ch0 accept
- s1_axis_tvalid  in  1  ch1 sample valid
- s1_axis_tdata  in  DW  ch1 sample, signed
- s1_axis_tready  out  1  ch1 accept
- f_axis_tvalid  out  1  sample to filter, valid
- f_axis_tdata  out  DW  sample to filter
- f_axis_tready  in  1  filter accepts
- f_res_tvalid  in  1  filter result valid (no back-pressure)
- f_res_tdata  in  FW  filter result, signed
- m0_axis_tvalid  out  1  ch0 result valid, 1-cycle pulse
- m0_axis_tdata  out  DW  ch0 result
- m1_axis_tvalid  out  1  ch1 result valid, 1-cycle pulse
- m1_axis_tdata  out  DW  ch1 result
- in_flight  out  $clog2(DEPTH)+1  tag FIFO occupancy
- pad_count  out  16  pads inserted, saturating
- err_orphan  out  1  sticky: result arrived with tag FIFO empty

Behaviour:
- Reset values: next_ch=0; tag FIFO empty (in_flight=0); timer=0; pad_count=0; err_orphan=0; all tvalid/tready outputs 0; m*_tdata=0.
- Input side:
  - Only channel next_ch is eligible. credit = (in_flight < DEPTH).
  - f_axis_tvalid = (s[next_ch]_tvalid | pad_req) & credit.
  - f_axis_tdata = 0 when pad_req, else s[next_ch]_tdata.
  - s[next_ch]_tready = f_axis_tready & credit & ~pad_req. The non-selected channel's tready is 0.
- Transfer: on f_axis_tvalid & f_axis_tready, push tag {pad, next_ch} and toggle next_ch.
- Pad timer:
  - Counts while s[next_ch]_tvalid=0 and s[~next_ch]_tvalid=1; otherwise clears.
  - When it reaches PAD_TIMEOUT, pad_req=1 until the pad transfers; the timer clears on that transfer.
  - pad_count increments once per pad transfer, saturating at 0xFFFF.
  - No pad logic is built when PAD_TIMEOUT=0.
- Output side, registered, 1-cycle latency:
  - On f_res_tvalid, pop the head tag. If pad=0, assert m[ch]_tvalid for 1 cycle with m[ch]_tdata = (f_res_tdata >>> SHIFT)[DW-1:0] (arithmetic shift, truncate). If pad=1, discard the result.
  - m*_tdata holds its last value while tvalid=0.
- Simultaneous push and pop in one cycle: in_flight unchanged; both operations take effect.
- f_res_tvalid with FIFO empty: result dropped, err_orphan set (cleared only by rst), no m*_tvalid.
- Full FIFO (in_flight=DEPTH): all s*_tready=0 and f_axis_tvalid=0. The pad timer keeps running. Inputs resume the cycle after a pop.
- Both channels valid: strict alternation, never two consecutive transfers from the same channel.
- rst mid-operation: all state returns to reset values; results already inside the filter arrive as orphans. Software pulses rst only while the filter is idle.

Test Plan:
- Both channels always valid, f_axis_tready=1, filter model returns each input ×2^20 after 8 cycles; ch0=+100, ch1=-7 -> f_axis_tdata alternates 100,-7,...; m0 pulses 100, m1 pulses -7, each 9 cycles after the matching input transfer.
- ch1 pre-asserted, ch0 silent, PAD_TIMEOUT=4 -> pad (tdata 0) issued after 4 stall cycles, then ch1 accepted; pad result not emitted on m0; pad_count=1.
- Filter never returns results, both channels valid -> exactly 16 transfers, then all tready=0; a single f_res_tvalid pulse -> exactly one more transfer.
- f_res_tvalid pulsed after reset with no inputs -> err_orphan=1, no m*_tvalid; stays set until rst.
- Push and pop in the same cycle with in_flight=5 -> in_flight stays 5; rst asserted mid-stream -> next cycle in_flight=0, next_ch=0, all valid outputs 0.
- Sign/shift check: f_res_tdata = -3·2^20 - 1 -> m tdata = -4; f_res_tdata = 2^51-1 -> tdata = 0x7FFFFFFF.
